// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - shared AES key-schedule types and constants
// Purpose: state encoding, word type and key word slicing constants used by
//          the key expansion sequencer and its word mixer.
// Ports:   none (package)
package aes_pkg;

  localparam int AES_NUM_ROUNDS = 10;

  typedef logic [31:0] word_t;

  // MSB position of each 32-bit word inside a 128-bit key; w0 is leftmost.
  localparam int KEY_W0_MSB = 127;
  localparam int KEY_W1_MSB = 95;
  localparam int KEY_W2_MSB = 63;
  localparam int KEY_W3_MSB = 31;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_EMIT,
    ST_G_REQ,
    ST_G_WAIT,
    ST_MIX,
    ST_FIN
  } state_t;

endpackage

// File: rtl/key_word_mix.sv
// rtl/key_word_mix.sv - chained XOR of four key words with the G result
// Purpose: produces the next four key words: each new word folds in the new
//          word to its left, the first folds in t.
// Ports:   w0..w3 - current key words
//          t      - G transform result
//          mix0..mix3 - next key words
module key_word_mix
  import aes_pkg::*;
(
  input  word_t w0,
  input  word_t w1,
  input  word_t w2,
  input  word_t w3,
  input  word_t t,
  output word_t mix0,
  output word_t mix1,
  output word_t mix2,
  output word_t mix3
);

  assign mix0 = w0 ^ t;
  assign mix1 = w1 ^ mix0;
  assign mix2 = w2 ^ mix1;
  assign mix3 = w3 ^ mix2;

endmodule

// File: rtl/key_expand_ctrl.sv
// rtl/key_expand_ctrl.sv - AES-128 key schedule sequencer
// Purpose: latches a cipher key and emits round keys 0..NUM_ROUNDS over a
//          valid/ready handshake, using an external G word transform.
// Ports:   clk, n_rst      - clock, asynchronous active-low reset
//          start, key_in   - begin expansion of key_in (sampled in IDLE)
//          key_valid, key_ready, round_key, round_idx - round key output
//          g_enable, g_in, g_round - request to the G transform
//          g_out, g_done   - G transform result
//          busy, done, error - status (error is a sticky G timeout)
module key_expand_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = AES_NUM_ROUNDS,
  parameter int G_TIMEOUT  = 16
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         start,
  input  logic [127:0] key_in,
  input  logic         key_ready,
  output logic         key_valid,
  output logic [127:0] round_key,
  output logic [3:0]   round_idx,
  output logic         g_enable,
  output logic [31:0]  g_in,
  output logic [3:0]   g_round,
  input  logic [31:0]  g_out,
  input  logic         g_done,
  output logic         busy,
  output logic         done,
  output logic         error
);

  localparam int CW = $clog2(G_TIMEOUT + 1);

  state_t      state, state_next;
  word_t       w0, w1, w2, w3, t;
  word_t       mix0, mix1, mix2, mix3;
  logic [CW-1:0] tcnt;

  logic load, capture, mix_en, tcnt_clr, tcnt_inc, abort, g_phase;

  key_word_mix u_mix (
    .w0   (w0),
    .w1   (w1),
    .w2   (w2),
    .w3   (w3),
    .t    (t),
    .mix0 (mix0),
    .mix1 (mix1),
    .mix2 (mix2),
    .mix3 (mix3)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) state <= ST_IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    key_valid  = 1'b0;
    g_enable   = 1'b0;
    done       = 1'b0;
    load       = 1'b0;
    capture    = 1'b0;
    mix_en     = 1'b0;
    tcnt_clr   = 1'b0;
    tcnt_inc   = 1'b0;
    abort      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          load       = 1'b1;
          state_next = ST_EMIT;
        end
      end
      ST_EMIT: begin
        key_valid = 1'b1;
        if (key_ready)
          state_next = (round_idx == 4'(NUM_ROUNDS)) ? ST_FIN : ST_G_REQ;
      end
      ST_G_REQ: begin
        g_enable   = 1'b1;
        tcnt_clr   = 1'b1;
        state_next = ST_G_WAIT;
      end
      ST_G_WAIT: begin
        if (g_done) begin
          capture    = 1'b1;
          state_next = ST_MIX;
        end else if (tcnt == CW'(G_TIMEOUT - 1)) begin
          // Last allowed wait cycle without a result: give up.
          abort      = 1'b1;
          state_next = ST_IDLE;
        end else begin
          tcnt_inc = 1'b1;
        end
      end
      ST_MIX: begin
        mix_en     = 1'b1;
        state_next = ST_EMIT;
      end
      ST_FIN: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      w0        <= '0;
      w1        <= '0;
      w2        <= '0;
      w3        <= '0;
      t         <= '0;
      round_idx <= '0;
      error     <= 1'b0;
      tcnt      <= '0;
    end else begin
      if (load) begin
        w0        <= key_in[KEY_W0_MSB -: 32];
        w1        <= key_in[KEY_W1_MSB -: 32];
        w2        <= key_in[KEY_W2_MSB -: 32];
        w3        <= key_in[KEY_W3_MSB -: 32];
        round_idx <= '0;
        error     <= 1'b0;
      end
      if (capture) t <= g_out;
      if (mix_en) begin
        w0        <= mix0;
        w1        <= mix1;
        w2        <= mix2;
        w3        <= mix3;
        round_idx <= round_idx + 4'd1;
      end
      if (tcnt_clr)      tcnt <= '0;
      else if (tcnt_inc) tcnt <= tcnt + CW'(1);
      if (abort) error <= 1'b1;
    end
  end

  // G request fields are only meaningful while a request is outstanding;
  // w3 and round_idx do not change in G_WAIT, so they stay held.
  assign g_phase   = (state == ST_G_REQ) || (state == ST_G_WAIT);
  assign g_in      = g_phase ? w3 : '0;
  assign g_round   = g_phase ? (round_idx + 4'd1) : '0;
  assign round_key = {w0, w1, w2, w3};
  assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_key_expand_ctrl.sv
// tb/tb_key_expand_ctrl.sv - directed testbench for key_expand_ctrl
module tb_key_expand_ctrl;

  localparam logic [127:0] KEY_F = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] F_R1  = 128'ha0fafe1788542cb123a339392a6c7605;
  localparam logic [127:0] F_R10 = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KEY_B = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] B_R10 = 128'h13111d7fe3944a17f307a78b4d2b30c5;

  localparam logic [2047:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16};

  logic         clk = 1'b0;
  logic         n_rst, start, key_ready, key_valid, g_enable, g_done, busy, done, error;
  logic [127:0] key_in, round_key;
  logic [3:0]   round_idx, g_round;
  logic [31:0]  g_in;
  logic [31:0]  g_out = '0;

  always #5 clk = ~clk;

  key_expand_ctrl dut (
    .clk(clk), .n_rst(n_rst), .start(start), .key_in(key_in),
    .key_ready(key_ready), .key_valid(key_valid), .round_key(round_key),
    .round_idx(round_idx), .g_enable(g_enable), .g_in(g_in), .g_round(g_round),
    .g_out(g_out), .g_done(g_done), .busy(busy), .done(done), .error(error)
  );

  int n_checks = 0;
  int n_pass   = 0;

  function automatic logic [7:0] sb(input logic [7:0] x);
    int i;
    i = int'(x);
    return SBOX[2047 - 8*i -: 8];
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1: return 8'h01;  4'd2: return 8'h02;  4'd3: return 8'h04;
      4'd4: return 8'h08;  4'd5: return 8'h10;  4'd6: return 8'h20;
      4'd7: return 8'h40;  4'd8: return 8'h80;  4'd9: return 8'h1b;
      4'd10: return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic [31:0] g_fn(input logic [31:0] w, input logic [3:0] r);
    logic [31:0] rot;
    rot = {w[23:0], w[31:24]};
    return {sb(rot[31:24]) ^ rcon(r), sb(rot[23:16]), sb(rot[15:8]), sb(rot[7:0])};
  endfunction

  function automatic logic [127:0] next_key(input logic [127:0] k, input logic [3:0] r);
    logic [31:0] a, b, c, d;
    a = k[127:96] ^ g_fn(k[31:0], r);
    b = k[95:64] ^ a;
    c = k[63:32] ^ b;
    d = k[31:0] ^ c;
    return {a, b, c, d};
  endfunction

  // Behavioural G: result appears six cycles after the request is seen.
  logic [3:0]  g_hang_round = '0;
  logic        g_done_m = 1'b0;
  logic        g_spur   = 1'b0;
  logic [31:0] g_lat_in;
  logic [3:0]  g_lat_round;
  int          g_cnt = 0;
  assign g_done = g_done_m | g_spur;

  initial begin
    forever begin
      @(negedge clk);
      g_done_m = 1'b0;
      if (!n_rst) begin
        g_cnt = 0;
      end else begin
        if (g_cnt > 0) begin
          g_cnt--;
          if (g_cnt == 0) begin
            g_done_m = 1'b1;
            g_out    = g_fn(g_lat_in, g_lat_round);
          end
        end
        if (g_enable && g_round != g_hang_round) begin
          g_lat_in    = g_in;
          g_lat_round = g_round;
          g_cnt       = 6;
        end
      end
    end
  end

  logic [127:0] exp_f [11];
  logic [127:0] exp_b [11];
  logic [127:0] rk [11];
  logic [3:0]   ridx [11];
  int           n_xfer, done_cnt;
  logic         first_g_seen, err_first;
  logic [31:0]  first_g_in;
  logic [3:0]   first_g_round;

  // Runs one expansion with key_ready high; returns on the cycle done is seen.
  task automatic run_keys(input logic [127:0] key, input bit spur);
    n_xfer = 0; done_cnt = 0; first_g_seen = 1'b0; err_first = 1'b1;
    @(negedge clk); start = 1'b1; key_in = key;
    @(negedge clk); start = 1'b0;
    err_first = error;
    for (int c = 0; c < 400; c++) begin
      if (key_valid && key_ready) begin
        if (n_xfer < 11) begin
          rk[n_xfer]   = round_key;
          ridx[n_xfer] = round_idx;
        end
        n_xfer++;
      end
      if (g_enable && !first_g_seen) begin
        first_g_seen = 1'b1; first_g_in = g_in; first_g_round = g_round;
      end
      g_spur = spur && key_valid;
      start  = spur && busy && !g_enable && (g_round != 4'd0);
      if (done) begin
        done_cnt++;
        break;
      end
      @(negedge clk);
    end
    g_spur = 1'b0;
    start  = 1'b0;
  endtask

  task automatic test_reset;
    n_checks++; if ({key_valid, g_enable, busy, done, error} !== 5'b0)
      $display("FAIL reset_ctrl got=%b want=00000", {key_valid, g_enable, busy, done, error}); else n_pass++;
    n_checks++; if (round_key !== 128'h0)
      $display("FAIL reset_round_key got=%h want=0", round_key); else n_pass++;
    n_checks++; if (round_idx !== 4'd0)
      $display("FAIL reset_round_idx got=%0d want=0", round_idx); else n_pass++;
    n_checks++; if ({g_in, g_round} !== 36'h0)
      $display("FAIL reset_g_req got=%h/%0d want=0/0", g_in, g_round); else n_pass++;
  endtask

  task automatic test_fips;
    int bad, extra_done;
    run_keys(KEY_F, 1'b0);
    n_checks++; if (rk[0] !== KEY_F) $display("FAIL fips_r0 got=%h want=%h", rk[0], KEY_F); else n_pass++;
    n_checks++; if (first_g_in !== 32'h09cf4f3c)
      $display("FAIL fips_first_g_in got=%h want=09cf4f3c", first_g_in); else n_pass++;
    n_checks++; if (first_g_round !== 4'd1)
      $display("FAIL fips_first_g_round got=%0d want=1", first_g_round); else n_pass++;
    n_checks++; if (rk[1] !== F_R1) $display("FAIL fips_r1 got=%h want=%h", rk[1], F_R1); else n_pass++;
    n_checks++; if (rk[10] !== F_R10) $display("FAIL fips_r10 got=%h want=%h", rk[10], F_R10); else n_pass++;
    for (int i = 2; i < 10; i++) begin
      n_checks++; if (rk[i] !== exp_f[i])
        $display("FAIL fips_r%0d got=%h want=%h", i, rk[i], exp_f[i]); else n_pass++;
    end
    bad = 0;
    for (int i = 0; i < 11; i++) if (ridx[i] !== 4'(i)) bad++;
    n_checks++; if (n_xfer !== 11 || bad !== 0)
      $display("FAIL fips_order xfers=%0d bad_idx=%0d want=11/0", n_xfer, bad); else n_pass++;
    extra_done = 0;
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (done) extra_done++; end
    n_checks++; if (done_cnt + extra_done !== 1)
      $display("FAIL fips_done_pulses got=%0d want=1", done_cnt + extra_done); else n_pass++;
    n_checks++; if (busy !== 1'b0) $display("FAIL fips_busy_end got=%b want=0", busy); else n_pass++;
  endtask

  task automatic test_backpressure;
    int n, stall, bad, ge;
    bit fin;
    logic [127:0] snap_k;
    n = 0; stall = 0; bad = 0; ge = 0; fin = 0; snap_k = '0;
    key_ready = 1'b0;
    @(negedge clk); start = 1'b1; key_in = KEY_F;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 600; c++) begin
      key_ready = 1'b0;
      if (n == 3 && stall > 0) begin
        if (!key_valid || round_key !== snap_k || round_idx !== 4'd3) bad++;
        if (g_enable) ge++;
      end
      if (key_valid) begin
        if (round_idx == 4'd3 && stall < 5) begin
          if (stall == 0) snap_k = round_key;
          stall++;
        end else begin
          key_ready = 1'b1;
          if (n < 11) rk[n] = round_key;
          n++;
        end
      end
      if (done) begin fin = 1; break; end
      @(negedge clk);
    end
    key_ready = 1'b1;
    n_checks++; if (stall !== 5 || bad !== 0)
      $display("FAIL bp_hold stall=%0d unstable=%0d want=5/0", stall, bad); else n_pass++;
    n_checks++; if (ge !== 0) $display("FAIL bp_no_g_enable got=%0d want=0", ge); else n_pass++;
    n_checks++; if (rk[3] !== exp_f[3]) $display("FAIL bp_r3 got=%h want=%h", rk[3], exp_f[3]); else n_pass++;
    n_checks++; if (fin !== 1'b1 || n !== 11 || rk[10] !== F_R10)
      $display("FAIL bp_complete done=%b xfers=%0d r10=%h want=1/11/%h", fin, n, rk[10], F_R10); else n_pass++;
  endtask

  task automatic test_timeout;
    int wait_cnt, nx;
    bit seen_done, fin;
    wait_cnt = 0; nx = 0; seen_done = 0; fin = 0;
    g_hang_round = 4'd3;
    @(negedge clk); start = 1'b1; key_in = KEY_F;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (key_valid) nx++;
      if (busy && g_round == 4'd3 && !g_enable) wait_cnt++;
      if (done) seen_done = 1;
      if (!busy) begin fin = 1; break; end
      @(negedge clk);
    end
    n_checks++; if (fin !== 1'b1 || wait_cnt !== 16)
      $display("FAIL to_wait_cycles ended=%b got=%0d want=1/16", fin, wait_cnt); else n_pass++;
    n_checks++; if (error !== 1'b1 || busy !== 1'b0)
      $display("FAIL to_error_busy got=%b/%b want=1/0", error, busy); else n_pass++;
    n_checks++; if (seen_done !== 1'b0 || nx !== 3)
      $display("FAIL to_no_done done=%b xfers=%0d want=0/3", seen_done, nx); else n_pass++;
    repeat (3) @(negedge clk);
    n_checks++; if (error !== 1'b1) $display("FAIL to_sticky got=%b want=1", error); else n_pass++;
    g_hang_round = 4'd0;
    run_keys(KEY_F, 1'b0);
    n_checks++; if (err_first !== 1'b0) $display("FAIL to_clear got=%b want=0", err_first); else n_pass++;
    n_checks++; if (done_cnt !== 1 || rk[10] !== F_R10)
      $display("FAIL to_rerun done=%0d r10=%h want=1/%h", done_cnt, rk[10], F_R10); else n_pass++;
  endtask

  task automatic test_reset_mid;
    bit found;
    found = 0;
    @(negedge clk); start = 1'b1; key_in = KEY_F;
    @(negedge clk); start = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (busy && g_round == 4'd6 && !g_enable) begin found = 1; break; end
      @(negedge clk);
    end
    n_checks++; if (found !== 1'b1) $display("FAIL rm_reach_round5 got=%b want=1", found); else n_pass++;
    n_rst = 1'b0;
    @(negedge clk);
    n_checks++; if ({key_valid, g_enable, busy, done, error} !== 5'b0 || round_key !== 128'h0 ||
                    round_idx !== 4'd0 || g_in !== 32'h0 || g_round !== 4'd0)
      $display("FAIL rm_outputs ctrl=%b key=%h idx=%0d g=%h/%0d want=0",
               {key_valid, g_enable, busy, done, error}, round_key, round_idx, g_in, g_round);
    else n_pass++;
    @(negedge clk); n_rst = 1'b1;
    run_keys(KEY_F, 1'b0);
    n_checks++; if (rk[0] !== KEY_F || ridx[0] !== 4'd0)
      $display("FAIL rm_restart key=%h idx=%0d want=%h/0", rk[0], ridx[0], KEY_F); else n_pass++;
    n_checks++; if (n_xfer !== 11 || done_cnt !== 1 || rk[10] !== F_R10)
      $display("FAIL rm_complete xfers=%0d done=%0d r10=%h", n_xfer, done_cnt, rk[10]); else n_pass++;
  endtask

  task automatic test_spurious;
    int bad;
    run_keys(KEY_F, 1'b1);
    bad = 0;
    for (int i = 0; i < 11; i++) if (rk[i] !== exp_f[i] || ridx[i] !== 4'(i)) bad++;
    n_checks++; if (n_xfer !== 11 || bad !== 0)
      $display("FAIL spur_keys xfers=%0d bad=%0d want=11/0", n_xfer, bad); else n_pass++;
    n_checks++; if (done_cnt !== 1) $display("FAIL spur_done got=%0d want=1", done_cnt); else n_pass++;
  endtask

  task automatic test_back_to_back;
    int d1, bad;
    run_keys(KEY_F, 1'b0);
    d1 = done_cnt;
    run_keys(KEY_B, 1'b0);
    n_checks++; if (d1 !== 1 || done_cnt !== 1)
      $display("FAIL b2b_done got=%0d/%0d want=1/1", d1, done_cnt); else n_pass++;
    n_checks++; if (rk[0] !== KEY_B) $display("FAIL b2b_r0 got=%h want=%h", rk[0], KEY_B); else n_pass++;
    n_checks++; if (rk[10] !== B_R10) $display("FAIL b2b_r10 got=%h want=%h", rk[10], B_R10); else n_pass++;
    bad = 0;
    for (int i = 0; i < 11; i++) if (rk[i] !== exp_b[i]) bad++;
    n_checks++; if (n_xfer !== 11 || bad !== 0)
      $display("FAIL b2b_keys xfers=%0d bad=%0d want=11/0", n_xfer, bad); else n_pass++;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1);
  end

  initial begin
    exp_f[0] = KEY_F;
    exp_b[0] = KEY_B;
    for (int i = 1; i < 11; i++) begin
      exp_f[i] = next_key(exp_f[i-1], 4'(i));
      exp_b[i] = next_key(exp_b[i-1], 4'(i));
    end
    n_rst = 1'b0; start = 1'b0; key_ready = 1'b1; key_in = '0;
    repeat (3) @(negedge clk);
    test_reset;
    n_rst = 1'b1;
    @(negedge clk);
    test_fips;
    test_backpressure;
    test_timeout;
    test_reset_mid;
    test_spurious;
    test_back_to_back;
    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
